// File: rtl/four_bit_binary_adder_subtractor.sv
// 4-bit ripple-carry adder/subtractor, registered outputs (M=1 subtracts).
// Define ADDSUB_INREG_EN to add an input register stage (latency 2).
module four_bit_binary_adder_subtractor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       M,
  output logic [3:0] S,
  output logic [3:0] C,
  output logic       Cout,
  output logic       V
);

  logic [3:0] a_op;
  logic [3:0] b_op;
  logic       m_op;

`ifdef ADDSUB_INREG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_op <= '0;
      b_op <= '0;
      m_op <= 1'b0;
    end else begin
      a_op <= A;
      b_op <= B;
      m_op <= M;
    end
  end
`else
  assign a_op = A;
  assign b_op = B;
  assign m_op = M;
`endif

  logic [3:0] bx;
  logic [3:0] sum;
  logic [3:0] cy;
  logic       carry;

  // Full-adder chain; M inverts B and seeds the carry for two's complement.
  always_comb begin
    bx    = '0;
    sum   = '0;
    cy    = '0;
    carry = m_op;
    for (int i = 0; i < 4; i++) begin
      bx[i]  = b_op[i] ^ m_op;
      sum[i] = a_op[i] ^ bx[i] ^ carry;
      cy[i]  = (a_op[i] & bx[i])
             | (carry & (a_op[i] ^ bx[i]));
      carry  = cy[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S    <= '0;
      C    <= '0;
      Cout <= 1'b0;
      V    <= 1'b0;
    end else begin
      S    <= sum;
      C    <= cy;
      Cout <= cy[3];
      V    <= cy[3] ^ cy[2];
    end
  end

endmodule

// File: tb/tb_four_bit_binary_adder_subtractor.sv
// Self-checking bench: directed, reset, exhaustive and random streams.
// Latency follows the ADDSUB_INREG_EN build option.
module tb_four_bit_binary_adder_subtractor;

`ifdef ADDSUB_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] A = '0;
  logic [3:0] B = '0;
  logic       M = 1'b0;
  logic [3:0] S;
  logic [3:0] C;
  logic       Cout;
  logic       V;

  int n_checks = 0;
  int n_fail   = 0;

  four_bit_binary_adder_subtractor dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .B    (B),
    .M    (M),
    .S    (S),
    .C    (C),
    .Cout (Cout),
    .V    (V)
  );

  always #5 clk = ~clk;

  // Reference from arithmetic: prefix sums give carries, signed range gives V.
  function automatic logic [9:0] model(input logic [3:0] a,
                                       input logic [3:0] b,
                                       input logic m);
    int ai, bxi, sa, sb, res, mask;
    logic [3:0] s, c, bx;
    logic co, v;
    bx  = m ? ~b : b;
    ai  = int'(a);
    bxi = int'(bx);
    for (int i = 0; i < 4; i++) begin
      mask = (2 << i) - 1;
      c[i] = 1'(((ai & mask) + (bxi & mask) + int'(m)) >> (i + 1));
    end
    s  = m ? 4'(a - b) : 4'(a + b);
    co = m ? (a >= b) : ((int'(a) + int'(b)) > 15);
    sa = int'($signed(a));
    sb = int'($signed(b));
    res = m ? sa - sb : sa + sb;
    v  = (res < -8) || (res > 7);
    return {s, c, co, v};
  endfunction

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({S, C, Cout, V} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_init: got %b want %b", {S, C, Cout, V}, 10'b0);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if ({S, C, Cout, V} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got %b want %b", {S, C, Cout, V}, 10'b0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [3:0]  ta [5] = '{4'b0001, 4'b0111, 4'b1111, 4'b0101, 4'b1000};
    logic [3:0]  tb [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0011, 4'b0001};
    logic        tm [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [9:0]  te [5] = '{
      {4'b0010, 4'b0001, 1'b0, 1'b0},
      {4'b1000, 4'b0111, 1'b0, 1'b1},
      {4'b0000, 4'b1111, 1'b1, 1'b0},
      {4'b0010, 4'b1101, 1'b1, 1'b0},
      {4'b0111, 4'b1000, 1'b1, 1'b1}};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      A = ta[k];
      B = tb[k];
      M = tm[k];
      repeat (LAT) @(negedge clk);
      n_checks++;
      if ({S, C, Cout, V} !== te[k]) begin
        n_fail++;
        $display("FAIL directed_%0d: got %b want %b",
                 k, {S, C, Cout, V}, te[k]);
      end
    end
  endtask

  task automatic test_mid_reset;
    @(negedge clk);
    A = 4'b1111;
    B = 4'b0001;
    M = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({S, C, Cout, V} !== 10'b0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got %b want %b",
               {S, C, Cout, V}, 10'b0);
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({S, C, Cout, V} !== 10'b0) begin
      n_fail++;
      $display("FAIL mid_reset_hold: got %b want %b",
               {S, C, Cout, V}, 10'b0);
    end
    rst_n = 1'b1;
    repeat (LAT) @(negedge clk);
    n_checks++;
    if ({S, C, Cout, V} !== {4'b0000, 4'b1111, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset_release: got %b want %b",
               {S, C, Cout, V}, {4'b0000, 4'b1111, 1'b1, 1'b0});
    end
  endtask

  // Streams one operation per cycle; n_ops<0 means exhaustive over 512.
  task automatic run_stream(input string name, input int n_ops);
    logic [9:0] expq[$];
    logic [9:0] exp_v;
    logic [8:0] vec;
    int total;
    total = (n_ops < 0) ? 512 : n_ops;
    for (int k = 0; k < total + LAT; k++) begin
      @(negedge clk);
      if (k >= LAT) begin
        exp_v = expq.pop_front();
        n_checks++;
        if ({S, C, Cout, V} !== exp_v) begin
          n_fail++;
          $display("FAIL %s_%0d: got %b want %b",
                   name, k - LAT, {S, C, Cout, V}, exp_v);
        end
      end
      if (k < total) begin
        vec = (n_ops < 0) ? 9'(k) : 9'($urandom_range(0, 511));
        A = vec[8:5];
        B = vec[4:1];
        M = vec[0];
        expq.push_back(model(A, B, M));
      end
    end
  endtask

  task automatic test_exhaustive;
    run_stream("exhaustive", -1);
  endtask

  task automatic test_back_to_back;
    run_stream("random", 300);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mid_reset();
    test_exhaustive();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
